// File: rtl/target_tracker_if.sv
// Detection handshake bundle between the marker detector and the target tracker.
// The detector side uses the master modport and the tracker side uses the slave modport.
interface target_tracker_if #(
   parameter int COORD_W = 11,
   parameter int PROB_W  = 11
) ();
   logic               det_valid;
   logic               det_ready;
   logic [COORD_W-1:0] det_h;
   logic [COORD_W-1:0] det_v;
   logic [COORD_W-1:0] det_diam;
   logic [PROB_W-1:0]  det_prob;

   modport master (
      output det_valid, det_h, det_v, det_diam, det_prob,
      input  det_ready
   );

   modport slave (
      input  det_valid, det_h, det_v, det_diam, det_prob,
      output det_ready
   );
endinterface

// File: rtl/target_tracker.sv
// Multi-target tracker: matches one detection at a time against a table of tracked markers,
// ages out stale entries and publishes a per-frame snapshot of the table.
module target_tracker #(
   parameter int NUM_TARGETS = 4,
   parameter int COORD_W     = 11,
   parameter int PROB_W      = 11,
   parameter int MAX_AGE     = 3
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               frame_start_in,
   target_tracker_if.slave    det,
   output logic [COORD_W-1:0] hcount_out   [NUM_TARGETS],
   output logic [COORD_W-1:0] vcount_out   [NUM_TARGETS],
   output logic [COORD_W-1:0] diameter_out [NUM_TARGETS],
   output logic               valid_out    [NUM_TARGETS],
   output logic               frame_done_out,
   output logic [7:0]         drop_count_out
);
   localparam int IDX_W = $clog2(NUM_TARGETS);
   localparam int AGE_W = $clog2(MAX_AGE + 2);
   localparam int DW    = 2 * COORD_W + 1;
   localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_AGE);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SCAN   = 2'd1;
   localparam logic [1:0] ST_UPDATE = 2'd2;
   localparam logic [1:0] ST_FRAME  = 2'd3;

   logic [1:0]         state_q, state_d;
   logic               pend_q, pend_d;
   logic               ready_q, ready_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               match_found_q, match_found_d;
   logic [IDX_W-1:0]   match_idx_q, match_idx_d;
   logic [COORD_W-1:0] det_h_q, det_h_d, det_v_q, det_v_d, det_diam_q, det_diam_d;
   logic [PROB_W-1:0]  det_prob_q, det_prob_d;
   logic [7:0]         drop_q, drop_d;
   logic               frame_done_q, frame_done_d;

   logic [COORD_W-1:0] tbl_h_q [NUM_TARGETS], tbl_h_d [NUM_TARGETS];
   logic [COORD_W-1:0] tbl_v_q [NUM_TARGETS], tbl_v_d [NUM_TARGETS];
   logic [COORD_W-1:0] tbl_diam_q [NUM_TARGETS], tbl_diam_d [NUM_TARGETS];
   logic [PROB_W-1:0]  tbl_prob_q [NUM_TARGETS], tbl_prob_d [NUM_TARGETS];
   logic               tbl_valid_q [NUM_TARGETS], tbl_valid_d [NUM_TARGETS];
   logic               tbl_seen_q [NUM_TARGETS], tbl_seen_d [NUM_TARGETS];
   logic [AGE_W-1:0]   tbl_age_q [NUM_TARGETS], tbl_age_d [NUM_TARGETS];

   logic [COORD_W-1:0] snap_h_q [NUM_TARGETS], snap_h_d [NUM_TARGETS];
   logic [COORD_W-1:0] snap_v_q [NUM_TARGETS], snap_v_d [NUM_TARGETS];
   logic [COORD_W-1:0] snap_diam_q [NUM_TARGETS], snap_diam_d [NUM_TARGETS];
   logic               snap_valid_q [NUM_TARGETS], snap_valid_d [NUM_TARGETS];

   // Distance test for the single entry currently addressed by the scan index.
   logic [COORD_W-1:0] sel_h, sel_v, dh, dv;
   logic [DW-1:0]      dh_w, dv_w, dm_w, dist_sq, diam_sq;
   logic               entry_match;

   always_comb begin
      sel_h       = tbl_h_q[idx_q];
      sel_v       = tbl_v_q[idx_q];
      dh          = (det_h_q >= sel_h) ? det_h_q - sel_h : sel_h - det_h_q;
      dv          = (det_v_q >= sel_v) ? det_v_q - sel_v : sel_v - det_v_q;
      dh_w        = DW'(dh);
      dv_w        = DW'(dv);
      dm_w        = DW'(tbl_diam_q[idx_q]);
      dist_sq     = dh_w * dh_w + dv_w * dv_w;
      diam_sq     = dm_w * dm_w;
      entry_match = tbl_valid_q[idx_q] && (dist_sq <= diam_sq);
   end

   logic             free_found;
   logic [IDX_W-1:0] free_idx;

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
         if (!tbl_valid_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      logic [AGE_W-1:0] age_inc;
      age_inc       = '0;
      state_d       = state_q;
      pend_d        = pend_q;
      idx_d         = idx_q;
      match_found_d = match_found_q;
      match_idx_d   = match_idx_q;
      det_h_d       = det_h_q;
      det_v_d       = det_v_q;
      det_diam_d    = det_diam_q;
      det_prob_d    = det_prob_q;
      drop_d        = drop_q;
      frame_done_d  = 1'b0;
      tbl_h_d       = tbl_h_q;
      tbl_v_d       = tbl_v_q;
      tbl_diam_d    = tbl_diam_q;
      tbl_prob_d    = tbl_prob_q;
      tbl_valid_d   = tbl_valid_q;
      tbl_seen_d    = tbl_seen_q;
      tbl_age_d     = tbl_age_q;
      snap_h_d      = snap_h_q;
      snap_v_d      = snap_v_q;
      snap_diam_d   = snap_diam_q;
      snap_valid_d  = snap_valid_q;

      if (state_q != ST_IDLE && frame_start_in) begin
         pend_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            // ready_q already implies IDLE with no pending frame, so a detection wins.
            if (det.det_valid && ready_q) begin
               det_h_d       = det.det_h;
               det_v_d       = det.det_v;
               det_diam_d    = det.det_diam;
               det_prob_d    = det.det_prob;
               idx_d         = '0;
               match_found_d = 1'b0;
               state_d       = ST_SCAN;
               if (frame_start_in) begin
                  pend_d = 1'b1;
               end
            end else if (frame_start_in || pend_q) begin
               pend_d  = 1'b0;
               state_d = ST_FRAME;
            end
         end
         ST_SCAN: begin
            if (!match_found_q && entry_match) begin
               match_found_d = 1'b1;
               match_idx_d   = idx_q;
            end
            if (idx_q == IDX_W'(NUM_TARGETS - 1)) begin
               state_d = ST_UPDATE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_UPDATE: begin
            if (match_found_q) begin
               tbl_seen_d[match_idx_q] = 1'b1;
               tbl_age_d[match_idx_q]  = '0;
               if (det_prob_q < tbl_prob_q[match_idx_q]) begin
                  tbl_h_d[match_idx_q]    = det_h_q;
                  tbl_v_d[match_idx_q]    = det_v_q;
                  tbl_diam_d[match_idx_q] = det_diam_q;
                  tbl_prob_d[match_idx_q] = det_prob_q;
               end
            end else if (free_found) begin
               tbl_h_d[free_idx]     = det_h_q;
               tbl_v_d[free_idx]     = det_v_q;
               tbl_diam_d[free_idx]  = det_diam_q;
               tbl_prob_d[free_idx]  = det_prob_q;
               tbl_valid_d[free_idx] = 1'b1;
               tbl_seen_d[free_idx]  = 1'b1;
               tbl_age_d[free_idx]   = '0;
            end else if (drop_q != 8'hFF) begin
               drop_d = drop_q + 8'd1;
            end
            state_d = ST_IDLE;
         end
         default: begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
               tbl_seen_d[i] = 1'b0;
               if (tbl_valid_q[i]) begin
                  if (tbl_seen_q[i]) begin
                     tbl_age_d[i] = '0;
                  end else begin
                     age_inc      = tbl_age_q[i] + AGE_W'(1);
                     tbl_age_d[i] = age_inc;
                     if (age_inc > AGE_LIMIT) begin
                        tbl_valid_d[i] = 1'b0;
                     end
                  end
               end
               snap_valid_d[i] = tbl_valid_d[i];
               snap_h_d[i]     = tbl_valid_d[i] ? tbl_h_q[i] : '0;
               snap_v_d[i]     = tbl_valid_d[i] ? tbl_v_q[i] : '0;
               snap_diam_d[i]  = tbl_valid_d[i] ? tbl_diam_q[i] : '0;
            end
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
         end
      endcase

      ready_d = (state_d == ST_IDLE) && !pend_d;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q       <= ST_IDLE;
         pend_q        <= 1'b0;
         ready_q       <= 1'b1;
         idx_q         <= '0;
         match_found_q <= 1'b0;
         match_idx_q   <= '0;
         det_h_q       <= '0;
         det_v_q       <= '0;
         det_diam_q    <= '0;
         det_prob_q    <= '0;
         drop_q        <= '0;
         frame_done_q  <= 1'b0;
         for (int i = 0; i < NUM_TARGETS; i++) begin
            tbl_h_q[i]      <= '0;
            tbl_v_q[i]      <= '0;
            tbl_diam_q[i]   <= '0;
            tbl_prob_q[i]   <= '0;
            tbl_valid_q[i]  <= 1'b0;
            tbl_seen_q[i]   <= 1'b0;
            tbl_age_q[i]    <= '0;
            snap_h_q[i]     <= '0;
            snap_v_q[i]     <= '0;
            snap_diam_q[i]  <= '0;
            snap_valid_q[i] <= 1'b0;
         end
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         ready_q       <= ready_d;
         idx_q         <= idx_d;
         match_found_q <= match_found_d;
         match_idx_q   <= match_idx_d;
         det_h_q       <= det_h_d;
         det_v_q       <= det_v_d;
         det_diam_q    <= det_diam_d;
         det_prob_q    <= det_prob_d;
         drop_q        <= drop_d;
         frame_done_q  <= frame_done_d;
         tbl_h_q       <= tbl_h_d;
         tbl_v_q       <= tbl_v_d;
         tbl_diam_q    <= tbl_diam_d;
         tbl_prob_q    <= tbl_prob_d;
         tbl_valid_q   <= tbl_valid_d;
         tbl_seen_q    <= tbl_seen_d;
         tbl_age_q     <= tbl_age_d;
         snap_h_q      <= snap_h_d;
         snap_v_q      <= snap_v_d;
         snap_diam_q   <= snap_diam_d;
         snap_valid_q  <= snap_valid_d;
      end
   end

   assign det.det_ready      = ready_q;
   assign frame_done_out     = frame_done_q;
   assign drop_count_out     = drop_q;

   for (genvar gi = 0; gi < NUM_TARGETS; gi++) begin : g_snap
      assign hcount_out[gi]   = snap_h_q[gi];
      assign vcount_out[gi]   = snap_v_q[gi];
      assign diameter_out[gi] = snap_diam_q[gi];
      assign valid_out[gi]    = snap_valid_q[gi];
   end
endmodule

// File: tb/tb_target_tracker.sv
// Directed, table-driven bench for target_tracker with hand-written multi-cycle corner cases.
module tb_target_tracker;
   localparam int N  = 4;
   localparam int CW = 11;
   localparam int PW = 11;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic          frame_start_in = 1'b0;
   logic [CW-1:0] hcount [N];
   logic [CW-1:0] vcount [N];
   logic [CW-1:0] diam [N];
   logic          valid [N];
   logic          frame_done;
   logic [7:0]    drop_count;

   int total = 0;
   int bad   = 0;

   target_tracker_if #(.COORD_W(CW), .PROB_W(PW)) det_if ();

   target_tracker #(.NUM_TARGETS(N), .COORD_W(CW), .PROB_W(PW), .MAX_AGE(3)) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .frame_start_in (frame_start_in),
      .det            (det_if),
      .hcount_out     (hcount),
      .vcount_out     (vcount),
      .diameter_out   (diam),
      .valid_out      (valid),
      .frame_done_out (frame_done),
      .drop_count_out (drop_count)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      bit has_det;
      int h, v, d, p;
      bit frame;
      int emask, eidx, eh, ev, ed, edrop;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   function automatic int snap_mask();
      int m = 0;
      for (int i = 0; i < N; i++) if (valid[i]) m |= (1 << i);
      return m;
   endfunction

   task automatic check_snap(input string tag, input int emask, input int eidx,
                             input int eh, input int ev, input int ed);
      chk({tag, "_mask"}, snap_mask(), emask);
      chk({tag, "_h"}, int'(hcount[eidx]), eh);
      chk({tag, "_v"}, int'(vcount[eidx]), ev);
      chk({tag, "_d"}, int'(diam[eidx]), ed);
   endtask

   // Offers a detection until accepted; returns once the tracker is ready again.
   task automatic send_det(input string tag, input int h, input int v, input int d, input int p,
                           input bit check_lat);
      int  n = 0;
      bit  acc = 0;
      det_if.det_valid = 1'b1;
      det_if.det_h     = CW'(h);
      det_if.det_v     = CW'(v);
      det_if.det_diam  = CW'(d);
      det_if.det_prob  = PW'(p);
      while (!acc && n < 50) begin
         acc = det_if.det_ready;
         tick();
         n++;
      end
      det_if.det_valid = 1'b0;
      if (!acc) chk({tag, "_accept_timeout"}, 0, 1);
      n = 0;
      while (!det_if.det_ready && n < 50) begin
         tick();
         n++;
      end
      if (check_lat) chk({tag, "_ready_lat"}, n, N + 1);
   endtask

   task automatic do_frame(input string tag);
      int n = 1;
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      while (!frame_done && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_frame_lat"}, n, 2);
      tick();
      chk({tag, "_done_width"}, int'(frame_done), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit ready_hi;

      vecs[0]  = '{1, 100,   50, 10, 20, 1, 1,  0, 100,  50,  10, 0};
      vecs[1]  = '{1, 106,   58, 12,  5, 1, 1,  0, 106,  58,  12, 0};
      vecs[2]  = '{1, 110,   60,  9, 30, 1, 1,  0, 106,  58,  12, 0};
      vecs[3]  = '{1, 500,    0, 10,  7, 0, 1,  0, 106,  58,  12, 0};
      vecs[4]  = '{1, 1000, 1000, 10, 7, 0, 1,  0, 106,  58,  12, 0};
      vecs[5]  = '{1, 1500,   0, 10,  7, 0, 1,  0, 106,  58,  12, 0};
      vecs[6]  = '{1, 2000, 2000, 10, 7, 1, 15, 0, 106,  58,  12, 1};
      vecs[7]  = '{0, 0, 0, 0, 0,        1, 15, 1, 500,   0,  10, 1};
      vecs[8]  = '{0, 0, 0, 0, 0,        1, 15, 2, 1000, 1000, 10, 1};
      vecs[9]  = '{0, 0, 0, 0, 0,        1, 14, 3, 1500,  0,  10, 1};
      vecs[10] = '{1, 500,    0, 10,  9, 0, 14, 1, 500,   0,  10, 1};
      vecs[11] = '{0, 0, 0, 0, 0,        1, 2,  1, 500,   0,  10, 1};
      vecs[12] = '{0, 0, 0, 0, 0,        1, 2,  2, 0,     0,   0, 1};

      det_if.det_valid = 1'b0;
      det_if.det_h     = '0;
      det_if.det_v     = '0;
      det_if.det_diam  = '0;
      det_if.det_prob  = '0;

      repeat (3) tick();
      rst_in = 1'b0;
      #1;
      chk("rst_ready", int'(det_if.det_ready), 1);
      chk("rst_done", int'(frame_done), 0);
      chk("rst_drop", int'(drop_count), 0);
      chk("rst_mask", snap_mask(), 0);
      $display("reset released");

      // Reset during SCAN abandons the detection.
      det_if.det_valid = 1'b1;
      det_if.det_h = 11'd100; det_if.det_v = 11'd50; det_if.det_diam = 11'd10; det_if.det_prob = 11'd20;
      tick();
      det_if.det_valid = 1'b0;
      chk("scanrst_busy", int'(det_if.det_ready), 0);
      tick();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      #1;
      chk("scanrst_ready", int'(det_if.det_ready), 1);
      do_frame("scanrst");
      check_snap("scanrst", 0, 0, 0, 0, 0);
      chk("scanrst_drop", int'(drop_count), 0);
      $display("reset mid-scan: mask=%0d", snap_mask());

      for (int i = 0; i < 13; i++) begin
         string tag = $sformatf("v%0d", i);
         if (vecs[i].has_det) send_det(tag, vecs[i].h, vecs[i].v, vecs[i].d, vecs[i].p, 1'b1);
         if (vecs[i].frame) do_frame(tag);
         check_snap(tag, vecs[i].emask, vecs[i].eidx, vecs[i].eh, vecs[i].ev, vecs[i].ed);
         chk({tag, "_drop"}, int'(drop_count), vecs[i].edrop);
         $display("vec %0d det=%0d (%0d,%0d,%0d,%0d) frame=%0d mask=%0d drop=%0d",
                  i, vecs[i].has_det, vecs[i].h, vecs[i].v, vecs[i].d, vecs[i].p,
                  vecs[i].frame, snap_mask(), drop_count);
      end

      // Frame request one cycle after acceptance is held pending until UPDATE finishes.
      det_if.det_valid = 1'b1;
      det_if.det_h = 11'd300; det_if.det_v = 11'd300; det_if.det_diam = 11'd10; det_if.det_prob = 11'd4;
      chk("pend_pre_ready", int'(det_if.det_ready), 1);
      tick();
      det_if.det_valid = 1'b0;
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      n = 1;
      ready_hi = 1'b0;
      while (!frame_done && n < 30) begin
         if (det_if.det_ready) ready_hi = 1'b1;
         tick();
         n++;
      end
      chk("pend_frame_lat", n, N + 3);
      chk("pend_ready_low", int'(ready_hi), 0);
      chk("pend_ready_after", int'(det_if.det_ready), 1);
      check_snap("pend", 3, 0, 300, 300, 10);
      $display("pending frame: latency=%0d mask=%0d", n, snap_mask());

      // Fill the table, then saturate the drop counter.
      send_det("fill2", 1200, 1200, 10, 4, 1'b1);
      send_det("fill3", 1800, 600, 10, 4, 1'b1);
      chk("fill_drop", int'(drop_count), 1);
      for (int i = 0; i < 253; i++) send_det("drop", 2000, 2000, 10, 4, 1'b0);
      chk("drop_254", int'(drop_count), 254);
      $display("drop count after 253 drops: %0d", drop_count);
      for (int i = 0; i < 50; i++) send_det("sat", 2000, 2000, 10, 4, 1'b0);
      chk("drop_sat", int'(drop_count), 255);
      $display("drop count after 50 more: %0d", drop_count);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
